// File: rtl/imem_load_ctrl.sv
// Boot-time instruction memory sequencer: streams a program image into the
// instruction RAM while the core is held in reset, then serves fetch reads.
module imem_load_ctrl #(
    parameter int          DEPTH       = 64,
    parameter int          AW          = 6,
    parameter int          RELEASE_CYC = 2,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    input  logic [31:0]   fetch_a,
    output logic [31:0]   fetch_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata,
    output logic          cpu_reset,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          err_overflow
);

    // A zero release delay would skip RELEASE entirely; clamp it to one cycle.
    localparam int            REL_INIT = (RELEASE_CYC < 1) ? 1 : RELEASE_CYC;
    localparam int            CW       = $clog2(REL_INIT + 1);
    localparam logic [CW-1:0] REL_LOAD = CW'(REL_INIT);
    localparam logic [CW-1:0] REL_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        ERR
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic [AW:0]     count_nxt;
    logic [CW-1:0]   rel_cnt, rel_nxt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_nxt = state;
        ptr_nxt   = ptr;
        count_nxt = word_count;
        rel_nxt   = rel_cnt;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;

        case (state)
            IDLE, RUN, ERR: begin
                if (ld_start) begin
                    state_nxt = LOAD;
                    ptr_nxt   = '0;
                    count_nxt = '0;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                // A restart outranks a beat presented in the same cycle.
                if (ld_start) begin
                    ptr_nxt   = '0;
                    count_nxt = '0;
                end else if (ld_valid) begin
                    mem_we    = 1'b1;
                    ptr_nxt   = ptr + 1'b1;
                    count_nxt = word_count + 1'b1;
                    if (ld_last) begin
                        state_nxt = RELEASE;
                        rel_nxt   = REL_LOAD;
                    end else if (ptr == PTR_LAST) begin
                        state_nxt = ERR;
                    end
                end
            end
            RELEASE: begin
                rel_nxt = rel_cnt - 1'b1;
                if (rel_cnt == REL_ONE) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            word_count <= '0;
            rel_cnt    <= '0;
            cpu_reset  <= 1'b1;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            word_count <= count_nxt;
            rel_cnt    <= rel_nxt;
            cpu_reset  <= (state_nxt != RUN);
        end
    end

    assign mem_waddr    = ptr;
    assign mem_wdata    = ld_data;
    assign load_done    = (state == RUN);
    assign err_overflow = (state == ERR);

    // Fetch is only honoured in RUN, word-aligned and inside the RAM window.
    assign mem_raddr = fetch_a[AW+1:2];
    assign fetch_rd  = ((state == RUN) && (fetch_a[1:0] == 2'b00) &&
                        (fetch_a[31:AW+2] == '0)) ? mem_rdata : NOP_WORD;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural 64x32 instruction RAM.
module tb_imem_load_ctrl;

    localparam int AW = 6;

    logic          clk;
    logic          reset;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic [31:0]   fetch_a;
    logic [31:0]   fetch_rd;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic          cpu_reset;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          err_overflow;

    logic [31:0] ram [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    imem_load_ctrl #(
        .DEPTH(64), .AW(AW), .RELEASE_CYC(2), .NOP_WORD(32'h00000013)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last),
        .fetch_a(fetch_a), .fetch_rd(fetch_rd),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .cpu_reset(cpu_reset), .load_done(load_done),
        .word_count(word_count), .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_raddr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, need %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [31:0] prog [0:3];
    int          hold_cnt;

    initial begin
        prog[0] = 32'h00500113;
        prog[1] = 32'h00C00193;
        prog[2] = 32'hFF718393;
        prog[3] = 32'h0023E233;

        reset    = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        fetch_a  = '0;
        for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
        ram[63] <= 32'h0000006F;

        // Reset state
        repeat (3) cycle();
        settle();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_fetch_nop", fetch_rd, 32'h00000013);
        check("rst_word_count", word_count, 0);
        check("rst_err", err_overflow, 0);
        reset = 1'b0;
        cycle();

        // Normal load with one idle cycle between beats
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        settle();
        check("load_ready", ld_ready, 1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == 3);
            settle();
            check("load_we", mem_we, 1);
            check("load_waddr", mem_waddr, i);
            check("load_wdata", mem_wdata, prog[i]);
            cycle();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            if (i < 3) begin
                settle();
                check("gap_no_we", mem_we, 0);
                cycle();
            end
        end
        fetch_a = 32'h8;
        settle();
        check("rel_hold_0", cpu_reset, 1);
        check("rel_ready", ld_ready, 0);
        check("rel_fetch_masked", fetch_rd, 32'h00000013);
        cycle();
        check("rel_hold_1", cpu_reset, 1);
        cycle();
        settle();
        check("run_cpu_reset", cpu_reset, 0);
        check("run_load_done", load_done, 1);
        check("run_word_count", word_count, 4);
        check("run_fetch_8", fetch_rd, 32'hFF718393);
        fetch_a = 32'h0;
        settle();
        check("run_fetch_0", fetch_rd, 32'h00500113);

        // Illegal and boundary fetches
        fetch_a = 32'h6;
        settle();
        check("fetch_misaligned", fetch_rd, 32'h00000013);
        fetch_a = 32'h100;
        settle();
        check("fetch_out_of_range", fetch_rd, 32'h00000013);
        fetch_a = 32'hFC;
        settle();
        check("fetch_word63", fetch_rd, 32'h0000006F);

        // Reload from RUN, then overflow the RAM
        cycle();
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        settle();
        check("reload_cpu_reset", cpu_reset, 1);
        check("reload_load_done", load_done, 0);
        check("reload_ready", ld_ready, 1);
        check("reload_count_clr", word_count, 0);
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h10000000 | i;
            if (i == 63) begin
                settle();
                check("ovf_we_63", mem_we, 1);
                check("ovf_waddr_63", mem_waddr, 63);
            end
            cycle();
        end
        settle();
        check("ovf_flag", err_overflow, 1);
        check("ovf_count", word_count, 64);
        check("ovf_ready", ld_ready, 0);
        check("ovf_no_we", mem_we, 0);
        hold_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_reset === 1'b1) hold_cnt++;
            cycle();
        end
        check("ovf_cpu_reset_hold", hold_cnt, 20);
        check("ovf_flag_sticky", err_overflow, 1);
        ld_valid = 1'b0;
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        settle();
        check("ovf_clear", err_overflow, 0);
        check("ovf_clear_count", word_count, 0);

        // Mid-load restart
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA0000000 | i;
            cycle();
        end
        settle();
        check("mid_count_3", word_count, 3);
        ld_start = 1'b1;
        ld_data  = 32'hC0C0C0C0;
        settle();
        check("restart_no_we", mem_we, 0);
        cycle();
        ld_start = 1'b0;
        settle();
        check("restart_count_clr", word_count, 0);
        ld_data = 32'hD0000000;
        settle();
        check("restart_we", mem_we, 1);
        check("restart_waddr", mem_waddr, 0);
        cycle();
        settle();
        check("restart_count_1", word_count, 1);
        ld_data = 32'hD0000001;
        settle();
        check("restart_waddr_1", mem_waddr, 1);
        cycle();

        // Synchronous reset mid-load, with start and valid also asserted
        reset    = 1'b1;
        ld_start = 1'b1;
        cycle();
        settle();
        check("midrst_cpu_reset", cpu_reset, 1);
        check("midrst_ready", ld_ready, 0);
        check("midrst_load_done", load_done, 0);
        check("midrst_count", word_count, 0);
        check("midrst_err", err_overflow, 0);
        check("midrst_no_we", mem_we, 0);
        reset    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        cycle();
        settle();
        check("midrst_idle", ld_ready, 0);
        check("midrst_idle_cpu", cpu_reset, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
